// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter: round-robin grant onto one shared completer, with one
// transfer in flight at a time and the response routed back to the granted requester.
//
// state  | meaning
// IDLE   | no transfer; arbitrate and capture the winner's payload
// SETUP  | m_apb_psel=1, m_apb_penable=0 for one cycle
// ACCESS | m_apb_psel=1, m_apb_penable=1 until m_apb_pready
// RESP   | one-cycle pready pulse to the granted requester
module apb_arbiter #(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      s0_apb_psel,
  input  logic                      s0_apb_penable,
  input  logic                      s0_apb_pwrite,
  input  logic [G_ADDR_WIDTH-1:0]   s0_apb_paddr,
  input  logic [G_REGWIDTH-1:0]     s0_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]   s0_apb_pstrb,
  output logic                      s0_apb_pready,
  output logic [G_REGWIDTH-1:0]     s0_apb_prdata,
  output logic                      s0_apb_pslverr,

  input  logic                      s1_apb_psel,
  input  logic                      s1_apb_penable,
  input  logic                      s1_apb_pwrite,
  input  logic [G_ADDR_WIDTH-1:0]   s1_apb_paddr,
  input  logic [G_REGWIDTH-1:0]     s1_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]   s1_apb_pstrb,
  output logic                      s1_apb_pready,
  output logic [G_REGWIDTH-1:0]     s1_apb_prdata,
  output logic                      s1_apb_pslverr,

  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                      m_apb_pready,
  input  logic [G_REGWIDTH-1:0]     m_apb_prdata,
  input  logic                      m_apb_pslverr
);

  localparam int C_STRB_W = G_REGWIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                    req_any;
  logic                    grant_nxt;
  logic                    grant;
  logic                    last_grant;
  logic                    cap_pwrite;
  logic [G_ADDR_WIDTH-1:0] cap_paddr;
  logic [G_REGWIDTH-1:0]   cap_pwdata;
  logic [C_STRB_W-1:0]     cap_pstrb;
  logic [G_REGWIDTH-1:0]   rsp_prdata;
  logic                    rsp_pslverr;

  // Requester-side penable carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = s0_apb_penable ^ s1_apb_penable;

  // Round-robin: on contention the port not granted last wins.
  always_comb begin
    req_any   = s0_apb_psel | s1_apb_psel;
    grant_nxt = 1'b0;
    if (s0_apb_psel && s1_apb_psel) begin
      grant_nxt = ~last_grant;
    end else if (s1_apb_psel) begin
      grant_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_any) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (m_apb_pready) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture and response registers; last_grant resets to 1 so port 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      cap_pwrite  <= 1'b0;
      cap_paddr   <= '0;
      cap_pwdata  <= '0;
      cap_pstrb   <= '0;
      rsp_prdata  <= '0;
      rsp_pslverr <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_any) begin
        grant      <= grant_nxt;
        last_grant <= grant_nxt;
        if (grant_nxt) begin
          cap_pwrite <= s1_apb_pwrite;
          cap_paddr  <= s1_apb_paddr;
          cap_pwdata <= s1_apb_pwdata;
          cap_pstrb  <= s1_apb_pstrb;
        end else begin
          cap_pwrite <= s0_apb_pwrite;
          cap_paddr  <= s0_apb_paddr;
          cap_pwdata <= s0_apb_pwdata;
          cap_pstrb  <= s0_apb_pstrb;
        end
      end
      if (state == ST_ACCESS && m_apb_pready) begin
        rsp_prdata  <= cap_pwrite ? '0 : m_apb_prdata;
        rsp_pslverr <= m_apb_pslverr;
      end
    end
  end

  // Outputs decode registered state and capture registers only.
  always_comb begin
    m_apb_psel     = 1'b0;
    m_apb_penable  = 1'b0;
    m_apb_pwrite   = 1'b0;
    m_apb_paddr    = '0;
    m_apb_pwdata   = '0;
    m_apb_pstrb    = '0;
    s0_apb_pready  = 1'b0;
    s0_apb_prdata  = '0;
    s0_apb_pslverr = 1'b0;
    s1_apb_pready  = 1'b0;
    s1_apb_prdata  = '0;
    s1_apb_pslverr = 1'b0;
    case (state)
      ST_SETUP, ST_ACCESS: begin
        m_apb_psel    = 1'b1;
        m_apb_penable = (state == ST_ACCESS);
        m_apb_pwrite  = cap_pwrite;
        m_apb_paddr   = cap_paddr;
        m_apb_pwdata  = cap_pwdata;
        m_apb_pstrb   = cap_pstrb;
      end
      ST_RESP: begin
        if (grant) begin
          s1_apb_pready  = 1'b1;
          s1_apb_prdata  = rsp_prdata;
          s1_apb_pslverr = rsp_pslverr;
        end else begin
          s0_apb_pready  = 1'b1;
          s0_apb_prdata  = rsp_prdata;
          s0_apb_pslverr = rsp_pslverr;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: fixed cycle-by-cycle stimulus with hand-computed
// expectations checked by immediate assertions.
module tb_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_apb_psel, s0_apb_penable, s0_apb_pwrite;
  logic [31:0] s0_apb_paddr, s0_apb_pwdata;
  logic [3:0]  s0_apb_pstrb;
  logic        s0_apb_pready, s0_apb_pslverr;
  logic [31:0] s0_apb_prdata;
  logic        s1_apb_psel, s1_apb_penable, s1_apb_pwrite;
  logic [31:0] s1_apb_paddr, s1_apb_pwdata;
  logic [3:0]  s1_apb_pstrb;
  logic        s1_apb_pready, s1_apb_pslverr;
  logic [31:0] s1_apb_prdata;
  logic        m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [31:0] m_apb_paddr, m_apb_pwdata;
  logic [3:0]  m_apb_pstrb;
  logic        m_apb_pready, m_apb_pslverr;
  logic [31:0] m_apb_prdata;

  int tests  = 0;
  int failed = 0;

  apb_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_apb_psel(s0_apb_psel), .s0_apb_penable(s0_apb_penable), .s0_apb_pwrite(s0_apb_pwrite),
    .s0_apb_paddr(s0_apb_paddr), .s0_apb_pwdata(s0_apb_pwdata), .s0_apb_pstrb(s0_apb_pstrb),
    .s0_apb_pready(s0_apb_pready), .s0_apb_prdata(s0_apb_prdata), .s0_apb_pslverr(s0_apb_pslverr),
    .s1_apb_psel(s1_apb_psel), .s1_apb_penable(s1_apb_penable), .s1_apb_pwrite(s1_apb_pwrite),
    .s1_apb_paddr(s1_apb_paddr), .s1_apb_pwdata(s1_apb_pwdata), .s1_apb_pstrb(s1_apb_pstrb),
    .s1_apb_pready(s1_apb_pready), .s1_apb_prdata(s1_apb_prdata), .s1_apb_pslverr(s1_apb_pslverr),
    .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
    .m_apb_paddr(m_apb_paddr), .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
    .m_apb_pready(m_apb_pready), .m_apb_prdata(m_apb_prdata), .m_apb_pslverr(m_apb_pslverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    s0_apb_psel = 0; s0_apb_penable = 0; s0_apb_pwrite = 0;
    s0_apb_paddr = 0; s0_apb_pwdata = 0; s0_apb_pstrb = 0;
    s1_apb_psel = 0; s1_apb_penable = 0; s1_apb_pwrite = 0;
    s1_apb_paddr = 0; s1_apb_pwdata = 0; s1_apb_pstrb = 0;
    m_apb_pready = 0; m_apb_prdata = 0; m_apb_pslverr = 0;

    // Reset state
    tick(); tick();
    chk("rst_m_psel", 32'(m_apb_psel), 0);
    chk("rst_m_paddr", m_apb_paddr, 0);
    chk("rst_s0_pready", 32'(s0_apb_pready), 0);
    chk("rst_s1_pready", 32'(s1_apb_pready), 0);
    rst = 1'b1;
    tick();
    chk("idle_m_psel", 32'(m_apb_psel), 0);

    // s0 write, zero-wait completer
    s0_apb_psel = 1; s0_apb_pwrite = 1; s0_apb_paddr = 32'h10;
    s0_apb_pwdata = 32'hDEADBEEF; s0_apb_pstrb = 4'hF;
    tick();
    chk("t1_setup_psel", 32'(m_apb_psel), 1);
    chk("t1_setup_pen", 32'(m_apb_penable), 0);
    chk("t1_setup_pwrite", 32'(m_apb_pwrite), 1);
    chk("t1_setup_paddr", m_apb_paddr, 32'h10);
    chk("t1_setup_pwdata", m_apb_pwdata, 32'hDEADBEEF);
    chk("t1_setup_pstrb", 32'(m_apb_pstrb), 32'hF);
    chk("t1_setup_s0_pready", 32'(s0_apb_pready), 0);
    s0_apb_pwdata = 32'h0BADF00D; s0_apb_paddr = 32'h99;
    m_apb_pready = 1; m_apb_prdata = 32'hFFFF0000;
    tick();
    chk("t1_access_pen", 32'(m_apb_penable), 1);
    chk("t1_access_paddr_held", m_apb_paddr, 32'h10);
    chk("t1_access_pwdata_held", m_apb_pwdata, 32'hDEADBEEF);
    tick();
    chk("t1_resp_s0_pready", 32'(s0_apb_pready), 1);
    chk("t1_resp_s0_prdata", s0_apb_prdata, 0);
    chk("t1_resp_m_psel", 32'(m_apb_psel), 0);
    chk("t1_resp_m_paddr", m_apb_paddr, 0);
    chk("t1_resp_s1_pready", 32'(s1_apb_pready), 0);
    s0_apb_psel = 0; m_apb_pready = 0;
    tick();
    chk("t1_idle_s0_pready", 32'(s0_apb_pready), 0);

    // s1 read, three completer wait states
    s1_apb_psel = 1; s1_apb_pwrite = 0; s1_apb_paddr = 32'h20;
    m_apb_prdata = 32'hFFFFFFFF;
    tick();
    chk("t2_setup_paddr", m_apb_paddr, 32'h20);
    chk("t2_setup_pwrite", 32'(m_apb_pwrite), 0);
    chk("t2_k1_s1_pready", 32'(s1_apb_pready), 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("t2_k%0d_pen", i), 32'(m_apb_penable), 1);
      chk($sformatf("t2_k%0d_s1_pready", i), 32'(s1_apb_pready), 0);
    end
    m_apb_pready = 1; m_apb_prdata = 32'h12345678;
    tick();
    chk("t2_k6_s1_pready", 32'(s1_apb_pready), 1);
    chk("t2_k6_s1_prdata", s1_apb_prdata, 32'h12345678);
    chk("t2_k6_s0_pready", 32'(s0_apb_pready), 0);
    s1_apb_psel = 0; m_apb_pready = 0;
    tick();
    chk("t2_idle_s1_pready", 32'(s1_apb_pready), 0);
    chk("t2_idle_s1_prdata", s1_apb_prdata, 0);

    // Contention after reset: grant order 0,1,0,1
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    s0_apb_psel = 1; s0_apb_pwrite = 0; s0_apb_paddr = 32'h100;
    s1_apb_psel = 1; s1_apb_pwrite = 0; s1_apb_paddr = 32'h200;
    m_apb_pready = 1; m_apb_prdata = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_grant%0d_paddr", i), m_apb_paddr, (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      tick();
      chk($sformatf("t3_grant%0d_s0_pready", i), 32'(s0_apb_pready), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("t3_grant%0d_s1_pready", i), 32'(s1_apb_pready), (i % 2 == 1) ? 1 : 0);
      tick();
    end
    s0_apb_psel = 0; s1_apb_psel = 0; m_apb_pready = 0;
    tick();

    // s1 write answered with pslverr
    s1_apb_psel = 1; s1_apb_pwrite = 1; s1_apb_paddr = 32'h40;
    s1_apb_pwdata = 32'h55; s1_apb_pstrb = 4'h3;
    m_apb_pready = 1; m_apb_pslverr = 1; m_apb_prdata = 32'h77777777;
    tick();
    chk("t4_setup_pstrb", 32'(m_apb_pstrb), 32'h3);
    chk("t4_setup_s1_pslverr", 32'(s1_apb_pslverr), 0);
    tick();
    tick();
    chk("t4_resp_s1_pready", 32'(s1_apb_pready), 1);
    chk("t4_resp_s1_pslverr", 32'(s1_apb_pslverr), 1);
    chk("t4_resp_s1_prdata", s1_apb_prdata, 0);
    chk("t4_resp_s0_pready", 32'(s0_apb_pready), 0);
    chk("t4_resp_s0_pslverr", 32'(s0_apb_pslverr), 0);
    chk("t4_resp_s0_prdata", s0_apb_prdata, 0);
    s1_apb_psel = 0; m_apb_pready = 0; m_apb_pslverr = 0;
    tick();
    chk("t4_idle_s1_pslverr", 32'(s1_apb_pslverr), 0);

    // Reset during ACCESS of an s0 read, then an s1 read
    s0_apb_psel = 1; s0_apb_pwrite = 0; s0_apb_paddr = 32'h50;
    tick();
    tick();
    chk("t5_access_pen", 32'(m_apb_penable), 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_m_psel", 32'(m_apb_psel), 0);
    chk("t5_rst_m_pen", 32'(m_apb_penable), 0);
    chk("t5_rst_m_paddr", m_apb_paddr, 0);
    chk("t5_rst_s0_pready", 32'(s0_apb_pready), 0);
    s0_apb_psel = 0; m_apb_pready = 1;
    tick();
    chk("t5_rst_hold_s0_pready", 32'(s0_apb_pready), 0);
    chk("t5_rst_hold_m_psel", 32'(m_apb_psel), 0);
    rst = 1'b1;
    s1_apb_psel = 1; s1_apb_pwrite = 0; s1_apb_paddr = 32'h60;
    m_apb_prdata = 32'hCAFEF00D;
    tick();
    chk("t5_setup_paddr", m_apb_paddr, 32'h60);
    tick();
    tick();
    chk("t5_resp_s1_pready", 32'(s1_apb_pready), 1);
    chk("t5_resp_s1_prdata", s1_apb_prdata, 32'hCAFEF00D);
    chk("t5_resp_s0_pready", 32'(s0_apb_pready), 0);
    s1_apb_psel = 0; m_apb_pready = 0;
    tick();
    chk("t5_idle_s1_pready", 32'(s1_apb_pready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
